// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial WIDTH-bit adder built on one 4-bit CLA slice
//
// Adder4: 4-bit carry-lookahead slice
//   a, b   in   4   nibble operands
//   cin    in   1   carry into bit 0
//   c      out  4   sum nibble
//   p, g   out  4   per-bit propagate / generate
//
// nibble_serial_adder: WIDTH-bit adder, one nibble per cycle, low nibble first
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    operand handshake (in_ready high only in IDLE)
//   a, b, cin             operands and carry in
//   out_valid, out_ready  result handshake (out_valid high only in DONE)
//   sum, cout, ovf        result, carry out, signed overflow
//   busy                  high while nibble passes are running

module Adder4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] c,
   output logic [3:0] p,
   output logic [3:0] g
);
   logic [3:0] cy;

   assign p = a ^ b;
   assign g = a & b;

   // Lookahead carries into each bit position.
   assign cy[0] = cin;
   assign cy[1] = g[0] | (p[0] & cin);
   assign cy[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign cy[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

   assign c = p ^ cy;
endmodule

module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);
   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [3:0]       s;
   logic [3:0]       p;
   logic [3:0]       g;
   logic             c3;
   logic             co;
   logic [WIDTH+3:0] res_cat;
   logic             unused_bits;

   Adder4 u_slice (
      .a   (a_sh[3:0]),
      .b   (b_sh[3:0]),
      .cin (carry),
      .c   (s),
      .p   (p),
      .g   (g)
   );

   // s[3]^p[3] recovers the carry into slice bit 3, so the nibble carry-out
   // and the MSB carry-in (needed for overflow) come from slice outputs only.
   assign c3 = s[3] ^ p[3];
   assign co = g[3] | (p[3] & c3);

   // New nibble enters at the top; the bottom nibble falls off.
   assign res_cat = {s, res};

   assign unused_bits = ^{p[2:0], g[2:0], res_cat[3:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         res       <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  carry    <= cin;
                  cnt      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 4;
               b_sh  <= b_sh >> 4;
               res   <= res_cat[WIDTH+3:4];
               carry <= co;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(NIB - 1)) begin
                  // Final pass: publish the full result in one edge so sum
                  // never shows partial data.
                  sum       <= res_cat[WIDTH+3:4];
                  cout      <= co;
                  ovf       <= c3 ^ co;
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder at WIDTH=16 and WIDTH=4

module tb_nibble_serial_adder;
   localparam int NRAND = 2000;

   logic        clk;
   logic        rst_n;

   logic        iv16, ir16, ov16, or16, cin16, co16, ovf16, busy16;
   logic [15:0] a16, b16, sum16;

   logic        iv4, ir4, ov4, or4, cin4, co4, ovf4, busy4;
   logic [3:0]  a4, b4, sum4;

   int total;
   int bad;

   nibble_serial_adder #(.WIDTH(16)) u16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
      .out_valid(ov16), .out_ready(or16),
      .sum(sum16), .cout(co16), .ovf(ovf16), .busy(busy16)
   );

   nibble_serial_adder #(.WIDTH(4)) u4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
      .out_valid(ov4), .out_ready(or4),
      .sum(sum4), .cout(co4), .ovf(ovf4), .busy(busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Golden model: plain integer arithmetic on w-bit operands.
   // Returns {ovf, cout, sum zero-extended to 16 bits}.
   function automatic logic [17:0] model(input int w, input logic [15:0] x,
                                         input logic [15:0] y, input logic c);
      longint unsigned m    = 64'd1 << w;
      longint          half = longint'(m / 2);
      longint unsigned xu   = x % m;
      longint unsigned yu   = y % m;
      longint unsigned tot  = xu + yu + c;
      longint          xs   = (longint'(xu) >= half) ? longint'(xu) - longint'(m) : longint'(xu);
      longint          ys   = (longint'(yu) >= half) ? longint'(yu) - longint'(m) : longint'(yu);
      longint          st   = xs + ys + longint'(c);
      logic            o    = (st >= half) || (st < -half);
      logic            k    = (tot >= m);
      logic [15:0]     s    = 16'(tot % m);
      return {o, k, s};
   endfunction

   // Issue one op on the 16-bit DUT, check result, latency and busy duration.
   task automatic op16(input string nm, input logic [15:0] ta, input logic [15:0] tb,
                       input logic tc, input logic [15:0] es, input logic eco, input logic eov);
      int t;
      int lat;
      int bz;
      @(negedge clk);
      a16 = ta; b16 = tb; cin16 = tc; iv16 = 1'b1; or16 = 1'b0;
      t = 0;
      while (!ir16 && t < 40) begin
         @(negedge clk);
         t++;
      end
      check({nm, "_ready"}, 32'(ir16), 32'd1);
      lat = 0;
      bz  = 0;
      @(negedge clk);
      iv16 = 1'b0;
      while (!ov16 && lat < 40) begin
         if (busy16) bz++;
         lat++;
         @(negedge clk);
      end
      check({nm, "_valid"}, 32'(ov16), 32'd1);
      check({nm, "_sum"}, 32'(sum16), 32'(es));
      check({nm, "_cout_ovf"}, {30'd0, co16, ovf16}, {30'd0, eco, eov});
      check({nm, "_latency"}, 32'(lat), 32'd4);
      check({nm, "_busy_cycles"}, 32'(bz), 32'd4);
      or16 = 1'b1;
      @(negedge clk);
      or16 = 1'b0;
      check({nm, "_back_idle"}, {30'd0, ov16, ir16}, {30'd0, 1'b0, 1'b1});
   endtask

   initial begin
      vec_t        vecs[6];
      logic [15:0] held_sum;
      logic        held_co, held_ov;
      int          lat, cnt_ov, cyc;
      int          sent16, sent4, done16, done4;
      logic        acc16, acc4;
      logic [17:0] q16[$];
      logic [17:0] q4[$];
      logic [17:0] exp;

      total = 0;
      bad   = 0;

      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

      iv16 = 0; or16 = 0; a16 = 0; b16 = 0; cin16 = 0;
      iv4  = 0; or4  = 0; a4  = 0; b4  = 0; cin4  = 0;
      rst_n = 1'b0;

      // Reset state
      #12;
      check("rst16_ready_valid_busy", {29'd0, ir16, ov16, busy16}, {29'd0, 3'b100});
      check("rst16_sum", 32'(sum16), 32'd0);
      check("rst16_cout_ovf", {30'd0, co16, ovf16}, 32'd0);
      check("rst4_ready_valid_busy", {29'd0, ir4, ov4, busy4}, {29'd0, 3'b100});
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel16_ready", 32'(ir16), 32'd1);

      // T1..T3 plus extra corners
      for (int i = 0; i < 6; i++)
         op16($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
              vecs[i].s, vecs[i].co, vecs[i].ov);

      // T4: stall in DONE for 5 cycles while a new operand pair is offered
      @(negedge clk);
      a16 = 16'h1111; b16 = 16'h2222; cin16 = 0; iv16 = 1;
      @(negedge clk);
      a16 = 16'h0F0F; b16 = 16'h0101; cin16 = 0;
      cyc = 0;
      while (!ov16 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("t4_valid", 32'(ov16), 32'd1);
      check("t4_first_sum", 32'(sum16), 32'h3333);
      held_sum = sum16; held_co = co16; held_ov = ovf16;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("t4_stall%0d", i),
               {12'd0, ov16, ir16, co16, ovf16, sum16},
               {12'd0, 1'b1, 1'b0, held_co, held_ov, held_sum});
      end
      or16 = 1'b1;
      @(negedge clk);
      or16 = 1'b0;
      check("t4_after_hs", {30'd0, ov16, ir16}, {30'd0, 2'b01});
      lat = 0;
      @(negedge clk);
      iv16 = 0;
      while (!ov16 && lat < 40) begin
         lat++;
         @(negedge clk);
      end
      check("t4_second_latency", 32'(lat), 32'd4);
      check("t4_second_sum", {14'd0, co16, ovf16, sum16}, {14'd0, 2'b00, 16'h1010});
      or16 = 1'b1;
      @(negedge clk);
      or16 = 1'b0;

      // T5: reset pulse mid-RUN with cnt==2
      @(negedge clk);
      a16 = 16'h1234; b16 = 16'h1111; cin16 = 0; iv16 = 1;
      check("t5_idle", 32'(ir16), 32'd1);
      @(negedge clk);
      iv16 = 0;
      @(negedge clk);
      @(negedge clk);
      check("t5_running", 32'(busy16), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5_async_ctl", {29'd0, ir16, ov16, busy16}, {29'd0, 3'b100});
      check("t5_async_res", {14'd0, co16, ovf16, sum16}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_ready_after", 32'(ir16), 32'd1);
      cnt_ov = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ov16) cnt_ov++;
      end
      check("t5_no_valid", 32'(cnt_ov), 32'd0);

      // T6: random traffic on both widths concurrently
      sent16 = 0; sent4 = 0; done16 = 0; done4 = 0;
      acc16 = 0; acc4 = 0; cyc = 0;
      while ((done16 < NRAND || done4 < NRAND) && cyc < 60000) begin
         @(negedge clk);
         cyc++;

         if (acc16) begin iv16 = 0; acc16 = 0; end
         if (!iv16 && sent16 < NRAND && $urandom_range(3) != 0) begin
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); iv16 = 1;
         end
         if (iv16 && ir16) begin
            q16.push_back(model(16, a16, b16, cin16));
            sent16++;
            acc16 = 1;
         end
         or16 = ($urandom_range(3) != 0);
         if (ov16 && or16) begin
            if (q16.size() == 0) check("rand16_unexpected", 32'd1, 32'd0);
            else begin
               exp = q16.pop_front();
               check("rand16", {14'd0, ovf16, co16, sum16}, {14'd0, exp});
            end
            done16++;
         end

         if (acc4) begin iv4 = 0; acc4 = 0; end
         if (!iv4 && sent4 < NRAND && $urandom_range(3) != 0) begin
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); iv4 = 1;
         end
         if (iv4 && ir4) begin
            q4.push_back(model(4, {12'd0, a4}, {12'd0, b4}, cin4));
            sent4++;
            acc4 = 1;
         end
         or4 = ($urandom_range(3) != 0);
         if (ov4 && or4) begin
            if (q4.size() == 0) check("rand4_unexpected", 32'd1, 32'd0);
            else begin
               exp = q4.pop_front();
               check("rand4", {14'd0, ovf4, co4, 12'd0, sum4}, {14'd0, exp});
            end
            done4++;
         end
      end
      check("rand_completed", 32'(done16 + done4), 32'(2 * NRAND));
      iv16 = 0; or16 = 0; iv4 = 0; or4 = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
